// File: rtl/cpu_run_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Execution-pacing and memory-mapped LED controller for the RISC-V debug
// environment. Sits between the board I/O and the CPU top level.
//
//  * Drives the CPU HALT input in one of four modes selected by MODE:
//      00 free run, 01 timed slow-run, 10 button single-step, 11 hold.
//    In slow-run the CPU is released for one clock every TICK_CYCLES+1 clocks.
//    In single-step a debounced press of STEP_BTN releases exactly one clock.
//  * Latches CPU stores to LED_ADDR into a registered LED bank, but only on
//    cycles where the CPU is actually running (HALT low).
//  * Counts executed (non-halted) CPU cycles into a saturating counter.
//
// Ports
//   CK_REF                   in   system clock
//   RST_N                    in   asynchronous active-low reset
//   MODE[1:0]                in   pacing mode switch (asynchronous, synchronised here)
//   STEP_BTN                 in   raw single-step push button, active high
//   MEM_ACCESS_READ_WRN      in   CPU data strobe, 0 = store
//   MEM_ACCESS_ADDRESS_BUS   in   CPU data address
//   MEM_ACCESS_DATA_OUT_BUS  in   CPU store data
//   HALT                     out  1 halts the CPU (registered)
//   LED[NUM_LEDS-1:0]        out  LED register (registered)
//   STEP_COUNT[CNT_W-1:0]    out  saturating count of non-halted cycles
// ----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int unsigned TICK_CYCLES     = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned NUM_LEDS        = 4,
    parameter logic [31:0] LED_ADDR        = 32'h0000_0001,
    parameter bit          LED_ONEHOT      = 1'b1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                CK_REF,
    input  logic                RST_N,
    input  logic [1:0]          MODE,
    input  logic                STEP_BTN,
    input  logic                MEM_ACCESS_READ_WRN,
    input  logic [31:0]         MEM_ACCESS_ADDRESS_BUS,
    input  logic [31:0]         MEM_ACCESS_DATA_OUT_BUS,
    output logic                HALT,
    output logic [NUM_LEDS-1:0] LED,
    output logic [CNT_W-1:0]    STEP_COUNT
);

    localparam int unsigned IDX_W = $clog2(NUM_LEDS);
    localparam int unsigned TMR_W = $clog2(TICK_CYCLES);
    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TICK_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [1:0] {RUN_ST, HOLD_ST, WAIT_ST, REL_ST} state_e;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [1:0] mode_meta_q, msync_q, mode_prev_q;
    logic       btn_meta_q, btn_sync_q;

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            mode_meta_q <= 2'b00;
            msync_q     <= 2'b00;
            mode_prev_q <= 2'b00;
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
        end else begin
            mode_meta_q <= MODE;
            msync_q     <= mode_meta_q;
            mode_prev_q <= msync_q;
            btn_meta_q  <= STEP_BTN;
            btn_sync_q  <= btn_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Button debounce: the debounced level only follows the synced level
    // after it has disagreed for DEBOUNCE_CYCLES consecutive clocks.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q;
    logic            btn_db_q, btn_db_prev_q;
    logic            step_pulse;

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            db_cnt_q      <= '0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
        end else begin
            btn_db_prev_q <= btn_db_q;
            if (btn_sync_q == btn_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                btn_db_q <= btn_sync_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    assign step_pulse = btn_db_q & ~btn_db_prev_q;

    // ------------------------------------------------------------------
    // Pacing FSM with registered HALT
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [TMR_W-1:0] timer_q;
    logic             halt_q;
    logic             mode_changed;

    // Only meaningful in WAIT_ST, where it flags a 01 <-> 10 switch.
    assign mode_changed = (msync_q != mode_prev_q);

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= HOLD_ST;
            timer_q <= '0;
            halt_q  <= 1'b1;
        end else begin
            unique case (msync_q)
                MODE_RUN: begin
                    state_q <= RUN_ST;
                    timer_q <= '0;
                    halt_q  <= 1'b0;
                end
                MODE_HOLD: begin
                    state_q <= HOLD_ST;
                    timer_q <= '0;
                    halt_q  <= 1'b1;
                end
                MODE_SLOW, MODE_STEP: begin
                    if (state_q != WAIT_ST) begin
                        // From RUN/HOLD, or the single release cycle of REL.
                        state_q <= WAIT_ST;
                        timer_q <= '0;
                        halt_q  <= 1'b1;
                    end else if (mode_changed) begin
                        timer_q <= '0;
                        if (msync_q == MODE_STEP && step_pulse) begin
                            state_q <= REL_ST;
                            halt_q  <= 1'b0;
                        end
                    end else if (msync_q == MODE_SLOW) begin
                        if (timer_q == TMR_LAST) begin
                            state_q <= REL_ST;
                            timer_q <= '0;
                            halt_q  <= 1'b0;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
                    end else if (step_pulse) begin
                        state_q <= REL_ST;
                        halt_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= HOLD_ST;
                    timer_q <= '0;
                    halt_q  <= 1'b1;
                end
            endcase
        end
    end

    assign HALT = halt_q;

    // ------------------------------------------------------------------
    // LED register: stores are only honoured while the CPU is running.
    // ------------------------------------------------------------------
    logic                led_wr;
    logic [NUM_LEDS-1:0] led_val;
    logic [NUM_LEDS-1:0] led_q;
    logic                unused_data;

    assign led_wr = ~MEM_ACCESS_READ_WRN & (MEM_ACCESS_ADDRESS_BUS == LED_ADDR) & ~halt_q;

    always_comb begin
        led_val = '0;
        if (LED_ONEHOT) begin
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                led_val[i] = (MEM_ACCESS_DATA_OUT_BUS[IDX_W-1:0] == IDX_W'(i));
            end
        end else begin
            led_val = MEM_ACCESS_DATA_OUT_BUS[NUM_LEDS-1:0];
        end
    end

    // Upper store-data bits never reach the LED bank.
    assign unused_data = ^MEM_ACCESS_DATA_OUT_BUS;

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            led_q <= '0;
        end else if (led_wr) begin
            led_q <= led_val;
        end
    end

    assign LED = led_q;

    // ------------------------------------------------------------------
    // Executed-cycle counter, saturating at all-ones.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] step_count_q;

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            step_count_q <= '0;
        end else if (!halt_q && (step_count_q != {CNT_W{1'b1}})) begin
            step_count_q <= step_count_q + CNT_W'(1);
        end
    end

    assign STEP_COUNT = step_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    localparam int unsigned TICK = 8;
    localparam int unsigned DEB  = 4;

    logic        CK_REF = 1'b0;
    logic        RST_N;
    logic [1:0]  MODE;
    logic        STEP_BTN;
    logic        MEM_ACCESS_READ_WRN;
    logic [31:0] MEM_ACCESS_ADDRESS_BUS;
    logic [31:0] MEM_ACCESS_DATA_OUT_BUS;
    logic        HALT;
    logic [3:0]  LED;
    logic [31:0] STEP_COUNT;
    logic        sat_halt;
    logic [3:0]  sat_led;
    logic [3:0]  sat_count;

    always #5 CK_REF = ~CK_REF;

    cpu_run_ctrl #(
        .TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .NUM_LEDS(4),
        .LED_ADDR(32'h0000_0001), .LED_ONEHOT(1'b1), .CNT_W(32)
    ) dut (
        .CK_REF(CK_REF), .RST_N(RST_N), .MODE(MODE), .STEP_BTN(STEP_BTN),
        .MEM_ACCESS_READ_WRN(MEM_ACCESS_READ_WRN),
        .MEM_ACCESS_ADDRESS_BUS(MEM_ACCESS_ADDRESS_BUS),
        .MEM_ACCESS_DATA_OUT_BUS(MEM_ACCESS_DATA_OUT_BUS),
        .HALT(HALT), .LED(LED), .STEP_COUNT(STEP_COUNT)
    );

    // Narrow counter instance so saturation is reachable.
    cpu_run_ctrl #(
        .TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .NUM_LEDS(4),
        .LED_ADDR(32'h0000_0001), .LED_ONEHOT(1'b1), .CNT_W(4)
    ) u_sat (
        .CK_REF(CK_REF), .RST_N(RST_N), .MODE(MODE), .STEP_BTN(STEP_BTN),
        .MEM_ACCESS_READ_WRN(MEM_ACCESS_READ_WRN),
        .MEM_ACCESS_ADDRESS_BUS(MEM_ACCESS_ADDRESS_BUS),
        .MEM_ACCESS_DATA_OUT_BUS(MEM_ACCESS_DATA_OUT_BUS),
        .HALT(sat_halt), .LED(sat_led), .STEP_COUNT(sat_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: inputs reach the controller two clocks late; the
    // button level is accepted once it has disagreed for DEB clocks;
    // a new press releases one clock in step mode; slow mode releases one
    // clock after TICK halted clocks.
    // ------------------------------------------------------------------
    logic [1:0]  m_mode_dly [2];
    logic [1:0]  m_mode_last;
    bit          m_btn_dly [2];
    bit          m_db, m_db_last;
    int          m_disagree;
    bit          m_halt;
    bit          m_paced;
    int          m_waited;
    logic [3:0]  m_led;
    longint      m_count;
    int          m_sat;

    task automatic model_reset();
        m_mode_dly[0] = 2'b00; m_mode_dly[1] = 2'b00; m_mode_last = 2'b00;
        m_btn_dly[0] = 0; m_btn_dly[1] = 0;
        m_db = 0; m_db_last = 0; m_disagree = 0;
        m_halt = 1; m_paced = 0; m_waited = 0;
        m_led = 4'b0000; m_count = 0; m_sat = 0;
    endtask

    task automatic model_step();
        logic [1:0] mode;
        bit press, n_halt, n_paced, n_db;
        int n_waited, n_dis;
        mode     = m_mode_dly[1];
        press    = m_db && !m_db_last;
        n_halt   = m_halt;
        n_paced  = m_paced;
        n_waited = m_waited;
        if (mode == 2'b00) begin
            n_halt = 0; n_paced = 0; n_waited = 0;
        end else if (mode == 2'b11) begin
            n_halt = 1; n_paced = 0; n_waited = 0;
        end else if (!(m_paced && m_halt)) begin
            n_halt = 1; n_paced = 1; n_waited = 0;
        end else if (mode != m_mode_last) begin
            n_waited = 0;
            if (mode == 2'b10 && press) n_halt = 0;
        end else if (mode == 2'b01) begin
            if (m_waited + 1 == TICK) begin
                n_halt = 0; n_waited = 0;
            end else begin
                n_waited = m_waited + 1;
            end
        end else if (press) begin
            n_halt = 0;
        end

        n_db  = m_db;
        n_dis = 0;
        if (m_btn_dly[1] != m_db) begin
            n_dis = m_disagree + 1;
            if (n_dis == DEB) begin
                n_db  = m_btn_dly[1];
                n_dis = 0;
            end
        end

        if (!MEM_ACCESS_READ_WRN && MEM_ACCESS_ADDRESS_BUS == 32'h1 && !m_halt)
            m_led = 4'b0001 << MEM_ACCESS_DATA_OUT_BUS[1:0];
        if (!m_halt) begin
            if (m_count < 64'hFFFF_FFFF) m_count++;
            if (m_sat < 15) m_sat++;
        end

        m_mode_last   = m_mode_dly[1];
        m_mode_dly[1] = m_mode_dly[0];
        m_mode_dly[0] = MODE;
        m_btn_dly[1]  = m_btn_dly[0];
        m_btn_dly[0]  = STEP_BTN;
        m_db_last     = m_db;
        m_db          = n_db;
        m_disagree    = n_dis;
        m_halt        = n_halt;
        m_paced       = n_paced;
        m_waited      = n_waited;
    endtask

    task automatic check_outputs();
        check_eq("halt", HALT, m_halt);
        check_eq("led", LED, m_led);
        check_eq("step_count", STEP_COUNT, m_count[31:0]);
        check_eq("sat_halt", sat_halt, m_halt);
        check_eq("sat_led", sat_led, m_led);
        check_eq("sat_count", sat_count, m_sat);
    endtask

    // Called on a falling edge with inputs already driven.
    task automatic cycle();
        model_step();
        @(posedge CK_REF);
        @(negedge CK_REF);
        check_outputs();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        model_reset();
        #1;
        check_eq("rst_halt", HALT, 1);
        check_eq("rst_led", LED, 0);
        check_eq("rst_count", STEP_COUNT, 0);
        @(negedge CK_REF);
        RST_N = 1'b1;
    endtask

    task automatic bus_idle();
        MEM_ACCESS_READ_WRN     = 1'b1;
        MEM_ACCESS_ADDRESS_BUS  = 32'h0;
        MEM_ACCESS_DATA_OUT_BUS = 32'h0;
    endtask

    task automatic bus_op(input logic rwn, input logic [31:0] addr, input logic [31:0] data);
        MEM_ACCESS_READ_WRN     = rwn;
        MEM_ACCESS_ADDRESS_BUS  = addr;
        MEM_ACCESS_DATA_OUT_BUS = data;
        cycle();
        bus_idle();
    endtask

    initial begin
        int lows, b2b, prev_low, hold_left, btn_left;
        logic [31:0] c0;

        MODE = 2'b00; STEP_BTN = 1'b0; bus_idle();
        @(negedge CK_REF);
        apply_reset();

        // Free run after reset
        cycles(4);
        check_eq("run_halt_low", HALT, 0);
        for (int i = 0; i < 3; i++) begin
            c0 = STEP_COUNT;
            cycle();
            check_eq("run_count_inc", STEP_COUNT, c0 + 1);
        end

        // Slow run: one release per TICK+1 clocks
        MODE = 2'b01;
        cycles(4);
        c0 = STEP_COUNT; lows = 0; b2b = 0; prev_low = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (!HALT) begin
                lows++;
                if (prev_low) b2b = 1;
            end
            prev_low = !HALT;
        end
        check_eq("slow_release_count", (lows == 4 || lows == 5), 1);
        check_eq("slow_no_back_to_back", b2b, 0);
        check_eq("slow_count_delta", STEP_COUNT - c0, lows);

        // Step mode: short glitch ignored, long press gives one release
        MODE = 2'b10;
        cycles(4);
        c0 = STEP_COUNT;
        STEP_BTN = 1'b1; cycles(2);
        STEP_BTN = 1'b0; cycles(8);
        check_eq("step_glitch_ignored", STEP_COUNT - c0, 0);
        c0 = STEP_COUNT; lows = 0;
        STEP_BTN = 1'b1;
        for (int i = 0; i < 10; i++) begin cycle(); if (!HALT) lows++; end
        STEP_BTN = 1'b0;
        for (int i = 0; i < 10; i++) begin cycle(); if (!HALT) lows++; end
        check_eq("step_one_release", lows, 1);
        check_eq("step_count_delta", STEP_COUNT - c0, 1);

        // LED writes while running
        MODE = 2'b00;
        cycles(4);
        bus_op(1'b0, 32'h1, 32'h2);
        check_eq("led_store", LED, 4'b0100);
        cycles(2);
        check_eq("led_sticky", LED, 4'b0100);
        bus_op(1'b0, 32'h2, 32'h3);
        check_eq("led_other_addr", LED, 4'b0100);
        bus_op(1'b1, 32'h1, 32'h1);
        check_eq("led_load", LED, 4'b0100);

        // Hold: stores ignored, counter frozen
        MODE = 2'b11;
        cycles(4);
        c0 = STEP_COUNT;
        bus_op(1'b0, 32'h1, 32'h3);
        cycles(3);
        check_eq("hold_led", LED, 4'b0100);
        check_eq("hold_count", STEP_COUNT, c0);
        MODE = 2'b00;
        cycles(4);
        bus_op(1'b0, 32'h1, 32'h3);
        check_eq("run_led_store", LED, 4'b1000);

        // Reset mid slow-run
        MODE = 2'b01;
        cycles(9);
        apply_reset();
        cycles(25);

        // Randomised mix of modes, presses, bus traffic and resets
        hold_left = 0; btn_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold_left == 0) begin
                MODE = 2'($urandom_range(0, 3));
                hold_left = $urandom_range(6, 40);
            end
            hold_left--;
            if (btn_left == 0) begin
                STEP_BTN = ~STEP_BTN;
                btn_left = $urandom_range(1, 12);
            end
            btn_left--;
            MEM_ACCESS_READ_WRN = 1'($urandom_range(0, 1));
            MEM_ACCESS_ADDRESS_BUS = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 2));
            MEM_ACCESS_DATA_OUT_BUS = $urandom;
            if ($urandom_range(0, 299) == 0) apply_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
